vit_dec_k: RTL

Parametrised rate-1/N hard-decision Viterbi decoder: the general successor to the fixed (2,1,3) decoder, with constraint length, code rate, generator polynomials, metric width and decision depth all set by parameters. Fully parallel add-compare-select (ACS) over 2^(K-1) states with register-exchange survivors, so it decodes one symbol per clock. Sits directly behind the channel slicer and emits one decoded bit per accepted symbol once the pipeline is filled.

---
 rtl/vit_dec_k.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vit_dec_k.sv
// vit_dec_k - parametrised rate-1/N hard-decision Viterbi decoder.
//
// Fully parallel add-compare-select over S = 2^(K-1) states with
// register-exchange survivors, so one received symbol is decoded per clock.
// After TB accepted symbols the decoder emits one bit per accepted symbol.
//
// Parameters:
//   K         constraint length (3..6)
//   N         code symbols per input bit (2..4)
//   G         generator set, G[n] at bits [(N-n)*K-1 -: K]
//   MW        path-metric width, 2^(MW-2) > 2*N*K
//   TB        decision depth / survivor length, >= K
//   SYNC_WIN  sync-check window in symbols (sync detect only)
//   SYNC_THR  sync-check threshold (sync detect only)
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   Rx[N-1:0]   received hard symbol, Rx[N-1-n] = code bit c_n
//   seq_ready   Rx valid; a symbol is accepted on every edge where it is 1
//   Dx          decoded bit
//   oe          one-cycle strobe marking a valid Dx
//   sync_error  loss-of-sync flag
//
// Build option: define VIT_SYNC_DETECT_EN to include the sync detector.
// Without it sync_error is tied low and SYNC_WIN/SYNC_THR have no effect.

module vit_dec_k #(
  parameter int               K        = 3,
  parameter int               N        = 2,
  parameter logic [N*K-1:0]   G        = {3'b111, 3'b101},
  parameter int               MW       = 8,
  parameter int               TB       = 15,
  parameter int               SYNC_WIN = 16,
  parameter int               SYNC_THR = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] Rx,
  input  logic         seq_ready,
  output logic         Dx,
  output logic         oe,
  output logic         sync_error
);

  localparam int S   = 1 << (K - 1);
  localparam int SW  = K - 1;
  localparam int BMW = $clog2(N + 1);
  localparam int CW  = $clog2(TB + 1);

  localparam logic [MW-1:0] PM_INIT  = {2'b01, {(MW - 2){1'b0}}};
  localparam logic [CW-1:0] FILL_MAX = CW'(TB);

  if (K < 3 || K > 6 || N < 2 || N > 4 || TB < K ||
      (1 << (MW - 2)) <= 2 * N * K || SYNC_WIN < 1 || SYNC_THR < 0) begin : g_bad_param
    $error("vit_dec_k: illegal parameter set");
  end

  // Expected code symbol for encoder register r = {u, state}.
  function automatic logic [N-1:0] enc_sym(input logic [K-1:0] r);
    logic [N-1:0] c;
    c = '0;
    for (int n = 0; n < N; n++) begin
      c[N-1-n] = ^(r & G[(N-n)*K-1 -: K]);
    end
    return c;
  endfunction

  function automatic logic [BMW-1:0] popcnt(input logic [N-1:0] v);
    logic [BMW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{(BMW - 1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic [MW-1:0] pm_q   [S];
  logic [MW-1:0] pm_raw [S];
  logic [MW-1:0] pm_d   [S];
  logic [TB-1:0] sv_q   [S];
  logic [TB-1:0] sv_d   [S];

  logic          all_msb;
  logic [SW-1:0] best_idx;
  logic [MW-1:0] best_pm;
  logic [CW-1:0] fill_q;
  logic          dx_q;
  logic          oe_q;

  // Per-state ACS. Both predecessors of state s share s[K-3:0] as their
  // upper bits; the input bit that leads into s is its MSB.
  for (genvar s = 0; s < S; s++) begin : g_acs
    localparam logic [SW-1:0] ST = SW'(s);
    localparam logic [SW-1:0] P0 = {ST[SW-2:0], 1'b0};
    localparam logic [SW-1:0] P1 = {ST[SW-2:0], 1'b1};
    localparam logic          U  = ST[SW-1];
    localparam logic [N-1:0]  E0 = enc_sym({U, P0});
    localparam logic [N-1:0]  E1 = enc_sym({U, P1});

    logic [BMW-1:0] bm0, bm1;
    logic [MW-1:0]  cand0, cand1;
    logic           sel1;
    logic [TB-1:0]  sv_win;

    assign bm0    = popcnt(Rx ^ E0);
    assign bm1    = popcnt(Rx ^ E1);
    assign cand0  = pm_q[P0] + {{(MW - BMW){1'b0}}, bm0};
    assign cand1  = pm_q[P1] + {{(MW - BMW){1'b0}}, bm1};
    // strict compare: a tie keeps p0
    assign sel1   = cand1 < cand0;
    assign sv_win = sel1 ? sv_q[P1] : sv_q[P0];

    assign pm_raw[s] = sel1 ? cand1 : cand0;
    assign sv_d[s]   = {sv_win[TB-2:0], U};
    assign pm_d[s]   = all_msb ? {1'b0, pm_raw[s][MW-2:0]} : pm_raw[s];
  end

  // Subtracting 2^(MW-1) from every metric at once keeps all relative
  // distances, which is all the ACS and best-state search depend on.
  always_comb begin
    all_msb = 1'b1;
    for (int s = 0; s < S; s++) begin
      all_msb = all_msb & pm_raw[s][MW-1];
    end
  end

  // Best state over the registered metrics; strict compare keeps the
  // lowest index on a tie.
  always_comb begin
    best_idx = '0;
    best_pm  = pm_q[0];
    for (int s = 1; s < S; s++) begin
      if (pm_q[s] < best_pm) begin
        best_idx = SW'(s);
        best_pm  = pm_q[s];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < S; s++) begin
        pm_q[s] <= (s == 0) ? '0 : PM_INIT;
        sv_q[s] <= '0;
      end
      fill_q <= '0;
      dx_q   <= 1'b0;
      oe_q   <= 1'b0;
    end else if (seq_ready) begin
      for (int s = 0; s < S; s++) begin
        pm_q[s] <= pm_d[s];
        sv_q[s] <= sv_d[s];
      end
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
      dx_q <= sv_q[best_idx][TB-1];
      oe_q <= (fill_q == FILL_MAX);
    end else begin
      oe_q <= 1'b0;
    end
  end

  assign Dx = dx_q;
  assign oe = oe_q;

`ifdef VIT_SYNC_DETECT_EN
  localparam int WW = $clog2(SYNC_WIN + 1);

  logic [MW-1:0] min_new;
  logic          rise;
  logic [WW-1:0] win_q;
  logic [WW-1:0] cnt_q;
  logic [WW-1:0] cnt_nxt;
  logic          sync_q;

  // Minimum of the pre-normalisation metrics, so it is directly comparable
  // with the registered minimum even on a normalising cycle.
  always_comb begin
    min_new = pm_raw[0];
    for (int s = 1; s < S; s++) begin
      if (pm_raw[s] < min_new) begin
        min_new = pm_raw[s];
      end
    end
  end

  assign rise    = min_new > best_pm;
  assign cnt_nxt = cnt_q + WW'(rise);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      win_q  <= '0;
      cnt_q  <= '0;
      sync_q <= 1'b0;
    end else if (seq_ready) begin
      if (win_q == WW'(SYNC_WIN - 1)) begin
        sync_q <= (int'(cnt_nxt) >= SYNC_THR);
        win_q  <= '0;
        cnt_q  <= '0;
      end else begin
        win_q <= win_q + 1'b1;
        cnt_q <= cnt_nxt;
      end
    end
  end

  assign sync_error = sync_q;
`else
  assign sync_error = 1'b0;
`endif

endmodule
